// File: rtl/axi_gpio_access_arbiter_if.sv
// AXI4-Lite bus between the access arbiter and the GPIO register slave
// (9-bit byte address, 32-bit data).
interface axi_gpio_access_arbiter_if;
    logic [8:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [8:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_gpio_access_arbiter.sv
// Round-robin arbiter that turns one requester's access at a time into a single
// AXI4-Lite read or write on the GPIO register port, with an optional response timeout.
module axi_gpio_access_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [9*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    input  logic [4*NUM_REQ-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  busy,
    axi_gpio_access_arbiter_if.master m_axi
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdData,
        StDone
    } state_e;

    state_e              state_q;
    logic [IdxW-1:0]     grant_q;
    logic [IdxW-1:0]     last_grant_q;
    logic [CntW-1:0]     tmo_cnt_q;

    logic                pick_valid;
    logic [IdxW-1:0]     pick_idx;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic                tmo_hit;

    logic [8:0]          addr_arr  [NUM_REQ];
    logic [31:0]         wdata_arr [NUM_REQ];
    logic [3:0]          wstrb_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_arr[g]  = req_addr[g*9 +: 9];
        assign wdata_arr[g] = req_wdata[g*32 +: 32];
        assign wstrb_arr[g] = req_wstrb[g*4 +: 4];
    end

    // First pending requester strictly after the last winner, wrapping around.
    always_comb begin : rr_pick
        int unsigned cand;
        cand       = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = 32'(last_grant_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_valid && req_valid[IdxW'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IdxW'(cand);
            end
        end
    end

    always_comb begin
        grant_onehot          = '0;
        grant_onehot[grant_q] = 1'b1;
    end

    assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt_q == CntW'(TIMEOUT_CYC));

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q        <= StIdle;
            grant_q        <= '0;
            last_grant_q   <= IdxW'(NUM_REQ - 1);
            tmo_cnt_q      <= '0;
            req_done       <= '0;
            rsp_rdata      <= '0;
            rsp_resp       <= '0;
            busy           <= 1'b0;
            m_axi.awaddr   <= '0;
            m_axi.awvalid  <= 1'b0;
            m_axi.wdata    <= '0;
            m_axi.wstrb    <= '0;
            m_axi.wvalid   <= 1'b0;
            m_axi.bready   <= 1'b0;
            m_axi.araddr   <= '0;
            m_axi.arvalid  <= 1'b0;
            m_axi.rready   <= 1'b0;
        end else begin
            req_done <= '0;
            if (state_q inside {StWrReq, StWrResp, StRdReq, StRdData}) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant_q   <= pick_idx;
                        busy      <= 1'b1;
                        tmo_cnt_q <= '0;
                        if (req_we[pick_idx]) begin
                            m_axi.awaddr  <= addr_arr[pick_idx];
                            m_axi.wdata   <= wdata_arr[pick_idx];
                            m_axi.wstrb   <= wstrb_arr[pick_idx];
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            state_q       <= StWrReq;
                        end else begin
                            m_axi.araddr  <= addr_arr[pick_idx];
                            m_axi.arvalid <= 1'b1;
                            state_q       <= StRdReq;
                        end
                    end
                end

                StWrReq: begin
                    if (tmo_hit) begin
                        m_axi.awvalid <= 1'b0;
                        m_axi.wvalid  <= 1'b0;
                        rsp_resp      <= 2'b11;
                        rsp_rdata     <= '0;
                        req_done      <= grant_onehot;
                        state_q       <= StDone;
                    end else begin
                        if (m_axi.awready) begin
                            m_axi.awvalid <= 1'b0;
                        end
                        if (m_axi.wready) begin
                            m_axi.wvalid <= 1'b0;
                        end
                        // Each channel is finished once already done or handshaking now.
                        if ((!m_axi.awvalid || m_axi.awready) &&
                            (!m_axi.wvalid || m_axi.wready)) begin
                            m_axi.bready <= 1'b1;
                            state_q      <= StWrResp;
                        end
                    end
                end

                StWrResp: begin
                    if (tmo_hit) begin
                        m_axi.bready <= 1'b0;
                        rsp_resp     <= 2'b11;
                        rsp_rdata    <= '0;
                        req_done     <= grant_onehot;
                        state_q      <= StDone;
                    end else if (m_axi.bvalid) begin
                        m_axi.bready <= 1'b0;
                        rsp_resp     <= m_axi.bresp;
                        rsp_rdata    <= '0;
                        req_done     <= grant_onehot;
                        state_q      <= StDone;
                    end
                end

                StRdReq: begin
                    if (tmo_hit) begin
                        m_axi.arvalid <= 1'b0;
                        rsp_resp      <= 2'b11;
                        rsp_rdata     <= '0;
                        req_done      <= grant_onehot;
                        state_q       <= StDone;
                    end else if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state_q       <= StRdData;
                    end
                end

                StRdData: begin
                    if (tmo_hit) begin
                        m_axi.rready <= 1'b0;
                        rsp_resp     <= 2'b11;
                        rsp_rdata    <= '0;
                        req_done     <= grant_onehot;
                        state_q      <= StDone;
                    end else if (m_axi.rvalid) begin
                        m_axi.rready <= 1'b0;
                        rsp_resp     <= m_axi.rresp;
                        rsp_rdata    <= m_axi.rdata;
                        req_done     <= grant_onehot;
                        state_q      <= StDone;
                    end
                end

                StDone: begin
                    last_grant_q <= grant_q;
                    busy         <= 1'b0;
                    rsp_rdata    <= '0;
                    rsp_resp     <= '0;
                    state_q      <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_gpio_access_arbiter.sv
// Bench for the GPIO access arbiter: reactive AXI4-Lite slave model, scoreboard of
// expected completions, a vector table and hand-written corner-case sequences.
module tb_axi_gpio_access_arbiter;

    localparam int unsigned NumReq     = 2;
    localparam int unsigned TimeoutCyc = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NumReq-1:0]       req_valid;
    logic [NumReq-1:0]       req_we;
    logic [9*NumReq-1:0]     req_addr;
    logic [32*NumReq-1:0]    req_wdata;
    logic [4*NumReq-1:0]     req_wstrb;
    logic [NumReq-1:0]       req_done;
    logic [31:0]             rsp_rdata;
    logic [1:0]              rsp_resp;
    logic                    busy;

    axi_gpio_access_arbiter_if bus ();

    axi_gpio_access_arbiter #(
        .NUM_REQ     (NumReq),
        .TIMEOUT_CYC (TimeoutCyc)
    ) dut (
        .m_axi_aclk   (clk),
        .m_axi_areset (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .req_done     (req_done),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .busy         (busy),
        .m_axi        (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  done;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        int          r;
        bit          we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d;
        int          w_d;
        int          b_d;
        int          ar_d;
        int          r_d;
        bit          ar_nv;
        logic [31:0] s_rd;
        logic [1:0]  s_rsp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    // Slave model configuration, changed only while the arbiter is idle.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          ar_never = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_resp = '0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_slave(input int aw, input int w, input int b, input int ar, input int rd,
                             input bit nv, input logic [31:0] rdat, input logic [1:0] rsp);
        aw_dly   = aw;
        w_dly    = w;
        b_dly    = b;
        ar_dly   = ar;
        r_dly    = rd;
        ar_never = nv;
        s_rdata  = rdat;
        s_resp   = rsp;
    endtask

    task automatic issue(input int r, input bit we, input logic [8:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        req_we[r]             = we;
        req_addr[r*9 +: 9]    = addr;
        req_wdata[r*32 +: 32] = wdata;
        req_wstrb[r*4 +: 4]   = wstrb;
        req_valid[r]          = 1'b1;
    endtask

    task automatic push_exp(input int r, input logic [31:0] rdata, input logic [1:0] resp);
        exp_t e;
        e.done  = 2'(1 << r);
        e.rdata = rdata;
        e.resp  = resp;
        sb_q.push_back(e);
    endtask

    // Cycles (negedges) until req_done[r]; 0 if the budget runs out.
    task automatic wait_done(input int r, input int budget, output int lat);
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (req_done[r] === 1'b1) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) check("wait_done", 0, 1);
    endtask

    // Reactive slave: ready/response after a programmed number of cycles.
    initial begin : slave
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;  bus.rresp = '0;
        forever begin
            @(negedge clk);
            if (bus.awvalid === 1'b1) begin bus.awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin bus.awready = 1'b0; aw_cnt = 0; end
            if (bus.wvalid === 1'b1) begin bus.wready = (w_cnt >= w_dly); w_cnt++; end
            else begin bus.wready = 1'b0; w_cnt = 0; end
            if (bus.arvalid === 1'b1) begin
                bus.arready = !ar_never && (ar_cnt >= ar_dly);
                ar_cnt++;
            end else begin
                bus.arready = 1'b0;
                ar_cnt = 0;
            end
            if (bus.bready === 1'b1) begin
                bus.bvalid = (b_cnt >= b_dly);
                bus.bresp  = s_resp;
                b_cnt++;
            end else begin
                bus.bvalid = 1'b0;
                b_cnt = 0;
            end
            if (bus.rready === 1'b1) begin
                bus.rvalid = (r_cnt >= r_dly);
                bus.rdata  = s_rdata;
                bus.rresp  = s_resp;
                r_cnt++;
            end else begin
                bus.rvalid = 1'b0;
                r_cnt = 0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && (req_done !== '0)) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(req_done), 0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_vec", 32'(req_done), 32'(e.done));
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                    check("busy_at_done", 32'(busy), 1);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int lat;
        set_slave(v.aw_d, v.w_d, v.b_d, v.ar_d, v.r_d, v.ar_nv, v.s_rd, v.s_rsp);
        issue(v.r, v.we, v.addr, v.wdata, v.wstrb);
        push_exp(v.r, v.exp_rdata, v.exp_resp);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("busy_n1", 32'(busy), 1);
                if (v.we) begin
                    check("awvalid_n1", 32'(bus.awvalid), 1);
                    check("wvalid_n1", 32'(bus.wvalid), 1);
                    check("awaddr", 32'(bus.awaddr), 32'(v.addr));
                    check("wdata", bus.wdata, v.wdata);
                    check("wstrb", 32'(bus.wstrb), 32'(v.wstrb));
                end else begin
                    check("arvalid_n1", 32'(bus.arvalid), 1);
                    check("araddr", 32'(bus.araddr), 32'(v.addr));
                end
            end
            if (v.ar_nv && c == v.exp_lat - 1) check("arvalid_pre_tmo", 32'(bus.arvalid), 1);
            if (req_done[v.r] === 1'b1) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) check("vec_no_done", 0, 1);
        else check("latency", lat, v.exp_lat);
        if (v.ar_nv) check("arvalid_post_tmo", 32'(bus.arvalid), 0);
        req_valid[v.r] = 1'b0;
        @(negedge clk);
        check("done_pulse_width", 32'(req_done), 0);
        check("busy_after_done", 32'(busy), 0);
    endtask

    vec_t vecs[7];

    initial begin : main
        int lat, prev, cyc, bready_cnt, first_bready;
        logic [151:0] outs;

        // r, we, addr, wdata, wstrb, aw, w, b, ar, r, ar_never, slave rdata, slave resp,
        // exp rdata, exp resp, exp latency
        vecs[0] = '{0, 1'b1, 9'h000, 32'hA5A5_0F0F, 4'hF, 0, 0, 0, 0, 0, 1'b0,
                    32'h0, 2'b00, 32'h0, 2'b00, 3};
        vecs[1] = '{1, 1'b0, 9'h1FC, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1'b0,
                    32'h1234_5678, 2'b00, 32'h1234_5678, 2'b00, 3};
        vecs[2] = '{0, 1'b0, 9'h008, 32'h0, 4'h0, 0, 0, 0, 2, 1, 1'b0,
                    32'hCAFE_F00D, 2'b01, 32'hCAFE_F00D, 2'b01, 6};
        vecs[3] = '{1, 1'b1, 9'h004, 32'h0000_00FF, 4'h1, 2, 0, 1, 0, 0, 1'b0,
                    32'h0, 2'b10, 32'h0, 2'b10, 6};
        vecs[4] = '{0, 1'b1, 9'h10C, 32'h8765_4321, 4'h6, 0, 3, 0, 0, 0, 1'b0,
                    32'h0, 2'b11, 32'h0, 2'b11, 6};
        vecs[5] = '{1, 1'b0, 9'h0A0, 32'h0, 4'h0, 0, 0, 0, 0, 3, 1'b0,
                    32'hDEAD_BEEF, 2'b10, 32'hDEAD_BEEF, 2'b10, 6};
        vecs[6] = '{0, 1'b0, 9'h1F0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1'b1,
                    32'hFFFF_FFFF, 2'b00, 32'h0, 2'b11, 10};

        // Reset with both requesters asserting reads.
        rst       = 1'b1;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        req_valid = 2'b11;
        req_addr[0 +: 9] = 9'h010;
        req_addr[9 +: 9] = 9'h020;
        set_slave(0, 0, 0, 0, 0, 1'b0, 32'h1111_2222, 2'b00);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            outs = {req_done, rsp_rdata, rsp_resp, busy, bus.awaddr, bus.awvalid, bus.wdata,
                    bus.wstrb, bus.wvalid, bus.bready, bus.araddr, bus.arvalid, bus.rready,
                    48'h0};
            check("reset_outputs_zero", 32'(|outs), 0);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        push_exp(0, 32'h1111_2222, 2'b00);
        push_exp(1, 32'h1111_2222, 2'b00);
        @(negedge clk);
        check("first_grant_arvalid", 32'(bus.arvalid), 1);
        check("first_grant_araddr", 32'(bus.araddr), 32'h010);
        wait_done(0, 20, lat);
        check("first_grant_latency", lat, 2);
        req_valid[0] = 1'b0;
        wait_done(1, 20, lat);
        req_valid[1] = 1'b0;
        @(negedge clk);

        // Contention: both hold reads, expect r0, r1, r0, r1 four cycles apart.
        set_slave(0, 0, 0, 0, 0, 1'b0, 32'h0BAD_F00D, 2'b00);
        req_addr[0 +: 9] = 9'h030;
        req_addr[9 +: 9] = 9'h040;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) push_exp(k % 2, 32'h0BAD_F00D, 2'b00);
        prev = 0;
        cyc  = 0;
        for (int k = 0; k < 4; k++) begin
            lat = 0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                cyc++;
                if (req_done !== '0) begin
                    lat = c;
                    break;
                end
            end
            if (lat == 0) check("contention_no_done", 0, 1);
            else if (k == 0) check("contention_first_lat", cyc, 3);
            else check("contention_gap", cyc - prev, 4);
            prev = cyc;
        end
        req_valid = 2'b00;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Split write: AW accepted on its 2nd cycle, W on its 5th.
        set_slave(1, 4, 0, 0, 0, 1'b0, 32'h0, 2'b00);
        issue(1, 1'b1, 9'h0F0, 32'h1357_9BDF, 4'hC);
        push_exp(1, 32'h0, 2'b00);
        lat = 0;
        bready_cnt = 0;
        first_bready = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 3) begin
                check("split_awvalid_low", 32'(bus.awvalid), 0);
                check("split_wvalid_high", 32'(bus.wvalid), 1);
                check("split_wdata_stable", bus.wdata, 32'h1357_9BDF);
            end
            if (bus.bready === 1'b1) begin
                bready_cnt++;
                if (first_bready == 0) first_bready = c;
            end
            if (req_done[1] === 1'b1) begin
                lat = c;
                break;
            end
        end
        check("split_latency", lat, 7);
        check("split_bready_cycles", bready_cnt, 1);
        check("split_done_after_b", lat - first_bready, 1);
        req_valid[1] = 1'b0;
        @(negedge clk);

        // Reset during WR_RESP: transaction is dropped without a done pulse.
        set_slave(0, 0, 5, 0, 0, 1'b0, 32'h0, 2'b00);
        issue(0, 1'b1, 9'h020, 32'h2468_ACE0, 4'hF);
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.bready === 1'b1) begin
                lat = c;
                break;
            end
        end
        check("wrresp_reached", lat, 2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_bready", 32'(bus.bready), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_done", 32'(req_done), 0);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_done !== '0) check("rst_mid_late_done", 32'(req_done), 0);
        end
        check("rst_mid_idle_busy", 32'(busy), 0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/axi_gpio_access_arbiter.md
Name: axi_gpio_access_arbiter

Overview:
AXI4-Lite master that shares the single AXI GPIO register port between NUM_REQ on-chip requesters (for example a test sequencer and a firmware bridge). It applies round-robin arbitration and converts each granted request into one complete AXI4-Lite read or write on the 9-bit, 32-bit GPIO register bus. It returns read data and response code to the winner with a one-cycle done pulse. It sits directly in front of the GPIO slave's s_axi_* port.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
TIMEOUT_CYC, 256, maximum cycles from grant to slave response before abort; 0 disables the timeout.

Ports:
m_axi_aclk  in  1  clock.
m_axi_areset  in  1  synchronous active-high reset.
req_valid  in  NUM_REQ  per-requester request, held until its req_done.
req_we  in  NUM_REQ  1 = write, 0 = read.
req_addr  in  9*NUM_REQ  byte address; slice i belongs to requester i.
req_wdata  in  32*NUM_REQ  write data.
req_wstrb  in  4*NUM_REQ  write byte strobes.
req_done  out  NUM_REQ  one-hot, one-cycle completion pulse.
rsp_rdata  out  32  read data, valid with req_done.
rsp_resp  out  2  AXI response, or 2'b11 on timeout.
busy  out  1  high from grant to done, inclusive.
m_axi_awaddr out 9; m_axi_awvalid out 1; m_axi_awready in 1.
m_axi_wdata out 32; m_axi_wstrb out 4; m_axi_wvalid out 1; m_axi_wready in 1.
m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1.
m_axi_araddr out 9; m_axi_arvalid out 1; m_axi_arready in 1.
m_axi_rdata in 32; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- Reset state:
  - All m_axi valid and ready outputs, req_done, rsp_rdata, rsp_resp and busy are 0. Address and data outputs are 0.
  - FSM is in IDLE. Last-grant pointer is NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE: if any req_valid is high, grant the first set bit searching upward from last_grant+1, wrapping around.
  - Latch the winner's we, addr, wdata and wstrb.
  - Next state is WR_REQ if we = 1, otherwise RD_REQ. busy goes to 1.
- WR_REQ:
  - awvalid and wvalid assert together on the first WR_REQ cycle.
  - Each valid drops the cycle after its own ready is sampled high. AW and W may complete in either order or in the same cycle.
  - Go to WR_RESP once both handshakes are done.
- WR_RESP: bready = 1. On bvalid, capture bresp into rsp_resp, set rsp_rdata = 0, go to DONE.
- RD_REQ: arvalid = 1 until arready is sampled, then go to RD_DATA.
- RD_DATA: rready = 1. On rvalid, capture rdata and rresp, go to DONE.
- DONE:
  - req_done[grant] = 1 and rsp_* are valid for exactly this cycle.
  - last_grant is updated to the winner; busy drops next cycle; return to IDLE.
  - Requests are not sampled in DONE.
- AXI rules:
  - Address and data are stable while their valid is high.
  - A valid is never withdrawn before its handshake, except on reset or timeout.
  - bready and rready are high only in their response states.
- Zero-wait latency:
  - req_valid is sampled in IDLE at cycle N, the aw/w or ar valids are high at N+1, and req_done is at N+3.
  - Each slave wait cycle adds one cycle.
- Requester contract:
  - Hold req_valid and request fields stable until req_done.
  - Deassert req_valid by the cycle after req_done, unless issuing a new request.
  - A back-to-back re-request is legal and loses priority to any other pending requester.
- Timeout (TIMEOUT_CYC > 0):
  - Counter starts at 0 on the first WR_REQ or RD_REQ cycle and increments each cycle until DONE.
  - If it reaches TIMEOUT_CYC, drop all valids and readies next cycle and go to DONE with rsp_resp = 2'b11 and rsp_rdata = 0.
- SLVERR and DECERR from the slave are passed through unchanged; the transaction is not retried.
- Reset mid-transaction: all outputs return to reset values on the next edge. The in-flight request is dropped with no req_done; the requester must re-issue.
- Slave responses arriving outside WR_RESP or RD_DATA are ignored.

Test Plan:
- Reset check: assert m_axi_areset for 3 cycles with req_valid = 2'b11 -> all outputs 0 throughout and for the first cycle after release; requester 0 is granted first.
- Single write, zero-wait slave: r0 writes addr 9'h000, data 32'hA5A5_0F0F, strb 4'hF at cycle N -> aw/w valid at N+1, bready at N+2, req_done = 2'b01 at N+3, rsp_resp = 0.
- Contention: both requesters hold a read continuously for 4 transactions -> grant order r0, r1, r0, r1 with no idle cycles other than DONE and IDLE.
- Split write handshake: awready at +1 and wready at +4 -> awvalid low after its handshake while wvalid stays high, then a single WR_RESP; done one cycle after bvalid.
- Read with error: slave returns rdata 32'hDEAD_BEEF, rresp 2'b10 after 3 wait cycles -> rsp_rdata = 32'hDEAD_BEEF, rsp_resp = 2'b10, req_done pulse exactly 1 cycle.
- Timeout and reset: TIMEOUT_CYC = 8 with arready never asserted -> arvalid drops, rsp_resp = 2'b11 and req_done 9 cycles after the first RD_REQ cycle. Separately, reset asserted during WR_RESP -> no req_done, bready = 0 next cycle.
